// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the byte sources, the scheduler and the serializer.
interface uart_tx_sched_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_din;
  logic              tx_start;
  logic              tx_done;
  logic              busy;

  // Byte sources and serializer: drive requests and the done pulse.
  modport master (output req_valid, req_data, req_last, tx_done,
                  input  req_ready, grant, tx_din, tx_start, busy);

  // Scheduler: accepts bytes and drives the serializer.
  modport slave  (input  req_valid, req_data, req_last, tx_done,
                  output req_ready, grant, tx_din, tx_start, busy);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte serializer among NREQ sources.
// A source that sends a byte without its last flag keeps the serializer
// (lock) until it sends a byte flagged last. An optional idle gap follows
// every completed byte.
//
// state | meaning
// IDLE  | arbitrate; the winner sees req_ready for one cycle (the transfer)
// WAIT  | byte handed to serializer, waiting for tx_done
// GAP   | inter-byte idle time, gap counter counts down to zero
module uart_tx_sched #(
  parameter int NREQ       = 3,
  parameter int GAP_CYCLES = 16,
  parameter int GAP_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.slave  bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] owner_q;
  logic             lock_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [NREQ-1:0]  grant_q;
  logic [7:0]       tx_din_q;
  logic             tx_start_q;

  logic             win_vld_d;
  logic [IDX_W-1:0] win_idx_d;
  logic [NREQ-1:0]  ready_d;
  logic [7:0]       win_data_d;

  // Pick the winner: the locked owner only, else the first valid after rr_ptr.
  // Walking the offsets downward lets the smallest offset overwrite the rest.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    if (state_q == IDLE) begin
      if (lock_q) begin
        win_vld_d = bus.req_valid[owner_q];
        win_idx_d = owner_q;
      end else begin
        for (int k = NREQ; k >= 1; k--) begin
          if (bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
            win_vld_d = 1'b1;
            win_idx_d = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
          end
        end
      end
    end
  end

  // One-hot accept strobe for the winner; doubles as the next grant value.
  always_comb begin
    ready_d = '0;
    if (win_vld_d) ready_d[win_idx_d] = 1'b1;
  end

  assign win_data_d    = bus.req_data[8*int'(win_idx_d) +: 8];
  assign bus.req_ready = ready_d;
  assign bus.grant     = grant_q;
  assign bus.tx_din    = tx_din_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.busy      = (state_q != IDLE);

  // Scheduler FSM with registered serializer outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(NREQ - 1);
      owner_q    <= '0;
      lock_q     <= 1'b0;
      gap_cnt_q  <= '0;
      grant_q    <= '0;
      tx_din_q   <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            tx_din_q   <= win_data_d;
            tx_start_q <= 1'b1;
            owner_q    <= win_idx_d;
            grant_q    <= ready_d;
            rr_ptr_q   <= win_idx_d;
            lock_q     <= ~bus.req_last[win_idx_d];
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // A done coincident with our own start pulse cannot be for this byte.
          if (bus.tx_done && !tx_start_q) begin
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
              if (!lock_q) grant_q <= '0;
            end else begin
              gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= IDLE;
            if (!lock_q) grant_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: one instance with a 4-cycle gap, one
// back-to-back instance, and a simple serializer responder.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NREQ(3)) ifa ();
  uart_tx_sched_if #(.NREQ(3)) ifb ();

  uart_tx_sched #(.NREQ(3), .GAP_CYCLES(4), .GAP_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  uart_tx_sched #(.NREQ(3), .GAP_CYCLES(0), .GAP_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  logic done_man  = 1'b0;
  logic done_auto = 1'b0;
  logic done_b    = 1'b0;
  logic ser_en    = 1'b0;
  int   ser_lat   = 10;

  assign ifa.tx_done = done_man | done_auto;
  assign ifb.tx_done = done_b;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  logic [2:0] watch_mask = '0;

  logic [7:0] log_q [$];
  int start_cnt = 0;
  int acc_cnt   = 0;
  int dbl_cnt   = 0;
  logic prev_start = 1'b0;

  logic [7:0] exp2 [5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
  logic [7:0] exp3 [4] = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
  logic [7:0] exp4 [3] = '{8'hC0, 8'hC1, 8'h77};

  // Monitor: log every started byte, count starts, accepts and stretched starts.
  always @(negedge clk) begin
    if (ifa.tx_start) begin
      log_q.push_back(ifa.tx_din);
      start_cnt++;
      if (prev_start) dbl_cnt++;
    end
    if (|ifa.req_ready) acc_cnt++;
    prev_start = ifa.tx_start;
  end

  // Serializer model: answers each start with a done pulse ser_lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (ifa.tx_start && ser_en) begin
        repeat (ser_lat) @(posedge clk);
        #1 done_auto = 1'b1;
        @(posedge clk);
        #1 done_auto = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    ifa.req_valid[i]      = v;
    ifa.req_data[8*i +: 8] = d;
    ifa.req_last[i]       = l;
  endtask

  task automatic clear_inputs();
    ifa.req_valid = '0;
    ifa.req_data  = '0;
    ifa.req_last  = '0;
    ifb.req_valid = '0;
    ifb.req_data  = '0;
    ifb.req_last  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ser_en = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns in the accept cycle of requester idx (posedge+2).
  task automatic wait_accept(input int idx, input int budget, input string tag);
    int n = 0;
    #1;
    while (!ifa.req_ready[idx] && n < budget) begin
      if ((ifa.req_ready & watch_mask) != 3'b000) viol++;
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (ifa.busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int lb;
    int a0;
    int s0;
    int d0;
    int n;

    clear_inputs();

    // Reset state.
    tick();
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_grant", 32'(ifa.grant), 0);
    chk("rst_tx_start", 32'(ifa.tx_start), 0);
    chk("rst_tx_din", 32'(ifa.tx_din), 0);
    chk("rst_ready", 32'(ifa.req_ready), 0);
    do_reset();

    // 1: single byte, gap timing.
    set_req(0, 1'b1, 8'h8A, 1'b1);
    #1 chk("t1_ready", 32'(ifa.req_ready), 32'h1);
    tick();
    chk("t1_ready_once", 32'(ifa.req_ready), 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    chk("t1_start", 32'(ifa.tx_start), 1);
    chk("t1_din", 32'(ifa.tx_din), 32'h8A);
    chk("t1_grant", 32'(ifa.grant), 32'h1);
    repeat (99) tick();
    chk("t1_din_hold", 32'(ifa.tx_din), 32'h8A);
    chk("t1_start_low", 32'(ifa.tx_start), 0);
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t1_gap_busy%0d", k), 32'(ifa.busy), 1);
      if (k < 4) tick();
    end
    tick();
    chk("t1_busy_fall", 32'(ifa.busy), 0);
    chk("t1_grant_clr", 32'(ifa.grant), 0);

    // 2: round robin across three continuously valid sources.
    do_reset();
    ser_en = 1'b1;
    lb = log_q.size();
    a0 = acc_cnt;
    s0 = start_cnt;
    d0 = dbl_cnt;
    set_req(0, 1'b1, 8'h11, 1'b1);
    set_req(1, 1'b1, 8'h22, 1'b1);
    set_req(2, 1'b1, 8'h33, 1'b1);
    n = 0;
    while (log_q.size() < lb + 5 && n < 600) begin
      tick();
      n++;
    end
    clear_inputs();
    chk("t2_timeout", 32'(n < 600), 1);
    wait_idle(100, "t2_idle");
    for (int i = 0; i < 5; i++) chk($sformatf("t2_byte%0d", i), 32'(log_q[lb+i]), 32'(exp2[i]));
    chk("t2_accepts", 32'(acc_cnt - a0), 5);
    chk("t2_starts", 32'(start_cnt - s0), 5);
    chk("t2_dbl_start", 32'(dbl_cnt - d0), 0);

    // 3: locked packet from req1 holds off req0.
    do_reset();
    ser_en = 1'b1;
    lb = log_q.size();
    viol = 0;
    set_req(1, 1'b1, 8'hA0, 1'b0);
    wait_accept(1, 20, "t3_acc_a0");
    tick();
    set_req(1, 1'b1, 8'hA1, 1'b0);
    set_req(0, 1'b1, 8'h55, 1'b1);
    watch_mask = 3'b001;
    wait_accept(1, 100, "t3_acc_a1");
    tick();
    set_req(1, 1'b1, 8'hA2, 1'b1);
    wait_accept(1, 100, "t3_acc_a2");
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    watch_mask = 3'b000;
    wait_accept(0, 100, "t3_acc_55");
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_idle(100, "t3_idle");
    for (int i = 0; i < 4; i++) chk($sformatf("t3_byte%0d", i), 32'(log_q[lb+i]), 32'(exp3[i]));
    chk("t3_ready0_early", 32'(viol), 0);

    // 4: locked owner stalls with req2 waiting.
    do_reset();
    ser_en = 1'b1;
    lb = log_q.size();
    viol = 0;
    set_req(0, 1'b1, 8'hC0, 1'b0);
    set_req(2, 1'b1, 8'h77, 1'b1);
    #1 chk("t4_first_ready", 32'(ifa.req_ready), 32'h1);
    wait_accept(0, 5, "t4_acc_c0");
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_idle(100, "t4_idle1");
    repeat (50) begin
      if (ifa.req_ready[2] || ifa.busy) viol++;
      tick();
    end
    chk("t4_stall", 32'(viol), 0);
    chk("t4_stall_grant", 32'(ifa.grant), 32'h1);
    set_req(0, 1'b1, 8'hC1, 1'b1);
    #1 chk("t4_resume_ready", 32'(ifa.req_ready), 32'h1);
    wait_accept(0, 5, "t4_acc_c1");
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_accept(2, 100, "t4_acc_77");
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    wait_idle(100, "t4_idle2");
    for (int i = 0; i < 3; i++) chk($sformatf("t4_byte%0d", i), 32'(log_q[lb+i]), 32'(exp4[i]));

    // 5: stray done pulses are ignored.
    do_reset();
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    chk("t5_idle_busy", 32'(ifa.busy), 0);
    chk("t5_idle_start", 32'(ifa.tx_start), 0);
    set_req(0, 1'b1, 8'h8A, 1'b1);
    wait_accept(0, 5, "t5_acc");
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    chk("t5_start", 32'(ifa.tx_start), 1);
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    chk("t5_hold_wait", 32'(ifa.busy), 1);
    repeat (3) tick();
    chk("t5_still_wait", 32'(ifa.busy), 1);
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    chk("t5_gap_busy", 32'(ifa.busy), 1);
    repeat (4) tick();
    chk("t5_idle_after", 32'(ifa.busy), 0);

    // 6: reset mid-byte, then rr restarts at req0.
    do_reset();
    set_req(0, 1'b1, 8'h8A, 1'b1);
    wait_accept(0, 5, "t6_acc");
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk("t6_in_wait", 32'(ifa.busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_start", 32'(ifa.tx_start), 0);
    chk("t6_rst_din", 32'(ifa.tx_din), 0);
    chk("t6_rst_grant", 32'(ifa.grant), 0);
    chk("t6_rst_busy", 32'(ifa.busy), 0);
    tick();
    tick();
    rst = 1'b0;
    s0 = start_cnt;
    repeat (3) tick();
    chk("t6_no_start", 32'(start_cnt - s0), 0);
    set_req(0, 1'b1, 8'h10, 1'b1);
    set_req(2, 1'b1, 8'h30, 1'b1);
    #1 chk("t6_ready", 32'(ifa.req_ready), 32'h1);
    tick();
    clear_inputs();
    chk("t6_din", 32'(ifa.tx_din), 32'h10);
    chk("t6_grant", 32'(ifa.grant), 32'h1);

    // 7: back-to-back instance.
    do_reset();
    ifb.req_valid[0]   = 1'b1;
    ifb.req_data[7:0]  = 8'h5A;
    ifb.req_last[0]    = 1'b1;
    #1 chk("t7_ready0", 32'(ifb.req_ready), 32'h1);
    tick();
    ifb.req_valid[0] = 1'b0;
    chk("t7_start0", 32'(ifb.tx_start), 1);
    ifb.req_valid[1]   = 1'b1;
    ifb.req_data[15:8] = 8'h6B;
    ifb.req_last[1]    = 1'b1;
    repeat (3) tick();
    done_b = 1'b1;
    #1 chk("t7_no_ready_wait", 32'(ifb.req_ready), 0);
    tick();
    done_b = 1'b0;
    #1;
    chk("t7_accept_next", 32'(ifb.req_ready), 32'h2);
    chk("t7_idle", 32'(ifb.busy), 0);
    chk("t7_grant_clr", 32'(ifb.grant), 0);
    tick();
    ifb.req_valid[1] = 1'b0;
    chk("t7_start1", 32'(ifb.tx_start), 1);
    chk("t7_din1", 32'(ifb.tx_din), 32'h6B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
